// File: rtl/bin_to_bcd_frame.sv
// Sequential double-dabble converter: 14-bit binary to four packed BCD digits for the
// on-screen number renderer. One iteration per clock, result published on completion only.
module bin_to_bcd_frame #(
    parameter int IN_WIDTH = 14,
    parameter int DIGITS   = 4,
    parameter int MAX_VAL  = 9999
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [IN_WIDTH-1:0]   value_in,
    input  logic                  load,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow
);

    localparam int ACC_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(IN_WIDTH + 1);
    localparam logic [IN_WIDTH-1:0] SAT_VAL  = IN_WIDTH'(MAX_VAL);
    localparam logic [CNT_W-1:0]    LAST_CNT = CNT_W'(IN_WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t                r_state;
    logic [IN_WIDTH-1:0]   r_bin;
    logic [ACC_W-1:0]      r_acc;
    logic [CNT_W-1:0]      r_cnt;
    logic [ACC_W-1:0]      r_bcd;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_ovf;

    logic [ACC_W-1:0]      w_adj;
    logic [ACC_W-1:0]      w_acc_next;

    // Per-nibble +3 when the digit is 5 or more; no carry can leave a nibble.
    function automatic logic [ACC_W-1:0] dabble_adjust(input logic [ACC_W-1:0] acc);
        logic [ACC_W-1:0] res;
        logic [3:0]       nib;
        res = acc;
        for (int i = 0; i < DIGITS; i++) begin
            nib = acc[4*i +: 4];
            if (nib >= 4'd5) begin
                res[4*i +: 4] = nib + 4'd3;
            end
        end
        return res;
    endfunction

    assign w_adj      = dabble_adjust(r_acc);
    assign w_acc_next = {w_adj[ACC_W-2:0], r_bin[IN_WIDTH-1]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_bin   <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_bcd   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (load) begin
                        // Saturate out-of-range input so the accumulator can never overflow.
                        if (value_in > SAT_VAL) begin
                            r_bin <= SAT_VAL;
                            r_ovf <= 1'b1;
                        end else begin
                            r_bin <= value_in;
                            r_ovf <= 1'b0;
                        end
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    r_acc <= w_acc_next;
                    r_bin <= {r_bin[IN_WIDTH-2:0], 1'b0};
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == LAST_CNT) begin
                        r_bcd   <= w_acc_next;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bcd_out  = r_bcd;
    assign busy     = r_busy;
    assign done     = r_done;
    assign overflow = r_ovf;

endmodule

// File: tb/tb_bin_to_bcd_frame.sv
// Randomized self-checking bench for bin_to_bcd_frame against a decimal-digit reference model.
module tb_bin_to_bcd_frame;

    localparam int MAXV = 9999;

    logic        clk;
    logic        reset_n;
    logic [13:0] value_in;
    logic        load;
    logic [15:0] bcd_out;
    logic        busy;
    logic        done;
    logic        overflow;

    int pass_cnt = 0;
    int total    = 0;

    bin_to_bcd_frame #(.IN_WIDTH(14), .DIGITS(4), .MAX_VAL(MAXV)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .value_in (value_in),
        .load     (load),
        .bcd_out  (bcd_out),
        .busy     (busy),
        .done     (done),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: saturate, then peel decimal digits with plain arithmetic.
    function automatic logic [15:0] model_bcd(input int v);
        int s;
        logic [15:0] r;
        s = (v > MAXV) ? MAXV : v;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(s % 10);
            s = s / 10;
        end
        return r;
    endfunction

    // Issue one load and follow it to done, reporting observations only.
    task automatic convert(input int v, input bit tog, input bit inj,
                           output int lat, output bit stable, output bit busy_ok,
                           output logic [15:0] res, output logic ovf);
        logic [15:0] prev;
        value_in = 14'(v);
        load = 1'b1;
        @(posedge clk); #1;
        load = 1'b0;
        prev = bcd_out;
        stable = 1'b1;
        busy_ok = (busy === 1'b1) && (done === 1'b0);
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            load = inj && (k == 3 || k == 13);
            if (load) value_in = 14'd555;
            if (tog) value_in = 14'($urandom);
            if (done === 1'b1) begin
                lat = k;
                if (busy !== 1'b0) busy_ok = 1'b0;
                break;
            end
            if (bcd_out !== prev) stable = 1'b0;
            if (busy !== 1'b1) busy_ok = 1'b0;
        end
        res = bcd_out;
        ovf = overflow;
    endtask

    task automatic test_reset();
        reset_n = 1'b1; load = 1'b0; value_in = '0;
        #2 reset_n = 1'b0;
        #1;
        total++;
        if ({bcd_out, busy, done, overflow} !== 19'd0)
            $display("FAIL reset_state: got bcd=%h busy=%b done=%b ovf=%b, want all 0",
                     bcd_out, busy, done, overflow);
        else pass_cnt++;
        repeat (2) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_values();
        int vals[5] = '{1234, 0, 9999, 12345, 7};
        int lat; bit st, bo; logic [15:0] r; logic o;
        for (int i = 0; i < 5; i++) begin
            convert(vals[i], 1'b0, 1'b0, lat, st, bo, r, o);
            total++;
            if (lat !== 14) $display("FAIL latency_%0d: got %0d want 14", vals[i], lat);
            else pass_cnt++;
            total++;
            if (r !== model_bcd(vals[i]))
                $display("FAIL bcd_%0d: got %h want %h", vals[i], r, model_bcd(vals[i]));
            else pass_cnt++;
            total++;
            if (o !== (vals[i] > MAXV))
                $display("FAIL ovf_%0d: got %b want %b", vals[i], o, vals[i] > MAXV);
            else pass_cnt++;
            total++;
            if (!st || !bo)
                $display("FAIL busy_stable_%0d: stable=%b busy_ok=%b want 1 1", vals[i], st, bo);
            else pass_cnt++;
            @(posedge clk); #1;
            total++;
            if (done !== 1'b0) $display("FAIL done_width_%0d: got %b want 0", vals[i], done);
            else pass_cnt++;
        end
    endtask

    task automatic test_random();
        int v, lat; bit st, bo; logic [15:0] r; logic o;
        for (int i = 0; i < 10; i++) begin
            v = int'($urandom_range(0, 16383));
            convert(v, 1'b0, 1'b0, lat, st, bo, r, o);
            total++;
            if (lat !== 14 || r !== model_bcd(v) || o !== (v > MAXV))
                $display("FAIL random_%0d: got lat=%0d bcd=%h ovf=%b want 14 %h %b",
                         v, lat, r, o, model_bcd(v), v > MAXV);
            else pass_cnt++;
        end
    endtask

    task automatic test_back_to_back();
        int lat; bit st, bo; logic [15:0] r; logic o;
        convert(42, 1'b0, 1'b1, lat, st, bo, r, o);
        total++;
        if (lat !== 14 || r !== 16'h0042)
            $display("FAIL ignore_busy: got lat=%0d bcd=%h want 14 0042", lat, r);
        else pass_cnt++;
        convert(555, 1'b0, 1'b0, lat, st, bo, r, o);
        total++;
        if (lat !== 14 || r !== 16'h0555)
            $display("FAIL load_in_done: got lat=%0d bcd=%h want 14 0555", lat, r);
        else pass_cnt++;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        int lat; bit st, bo, seen; logic [15:0] r; logic o;
        convert(1234, 1'b0, 1'b0, lat, st, bo, r, o);
        @(posedge clk); #1;
        value_in = 14'd8765; load = 1'b1;
        @(posedge clk); #1;
        load = 1'b0;
        repeat (6) @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        total++;
        if (bcd_out !== 16'h0 || busy !== 1'b0 || done !== 1'b0)
            $display("FAIL async_reset: got bcd=%h busy=%b done=%b want 0 0 0", bcd_out, busy, done);
        else pass_cnt++;
        @(negedge clk) reset_n = 1'b1;
        seen = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            if (done !== 1'b0 || busy !== 1'b0 || bcd_out !== 16'h0) seen = 1'b1;
        end
        total++;
        if (seen) $display("FAIL post_reset_idle: got activity=%b want 0", seen);
        else pass_cnt++;
        convert(4321, 1'b0, 1'b0, lat, st, bo, r, o);
        total++;
        if (lat !== 14 || r !== 16'h4321)
            $display("FAIL after_reset: got lat=%0d bcd=%h want 14 4321", lat, r);
        else pass_cnt++;
    endtask

    task automatic test_toggle();
        int lat; bit st, bo; logic [15:0] r; logic o;
        convert(3000, 1'b1, 1'b0, lat, st, bo, r, o);
        total++;
        if (lat !== 14 || r !== 16'h3000 || o !== 1'b0)
            $display("FAIL toggle_input: got lat=%0d bcd=%h ovf=%b want 14 3000 0", lat, r, o);
        else pass_cnt++;
        total++;
        if (!st) $display("FAIL bcd_stable: got stable=%b want 1", st);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_values();
        test_random();
        test_back_to_back();
        test_reset_mid();
        test_toggle();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
